// File: rtl/spi_controller.sv
// Memory-mapped SPI master (mode 0, MSB first, 8-bit frames) with a 16-byte register window.
// Software drives chip select; a TXDATA write while idle starts one frame.
module spi_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2200,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        sel,
    output logic        sckPort,
    output logic        mosiPort,
    input  logic        misoPort,
    output logic        csnPort,
    output logic        spiIRQ
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_div;
    logic        r_cs;
    logic        r_ie;
    logic        r_rxv;
    logic        r_ovr;
    logic [7:0]  r_rxdata;
    logic [7:0]  r_shreg;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_divcnt;
    logic [7:0]  r_div_act;
    logic        r_sck;
    logic        r_mosi;

    logic        w_wr;
    logic [1:0]  w_off;
    logic        w_busy;
    logic        w_div_hit;
    logic        w_tx_start;
    logic        w_done;
    logic        w_clr_rxv;
    logic        w_clr_ovr;
    logic        w_unused;

    assign sel        = (A[31:4] == BASE_ADDR[31:4]);
    assign w_off      = A[3:2];
    assign w_wr       = sel & WE;
    assign w_busy     = (r_state != S_IDLE);
    assign w_div_hit  = (r_divcnt == r_div_act);
    assign w_tx_start = w_wr && (w_off == 2'd2) && (r_state == S_IDLE);
    assign w_done     = (r_state == S_HIGH) && w_div_hit && (r_bitcnt == 3'd7);
    assign w_clr_rxv  = w_wr && (w_off == 2'd1) && WD[1];
    assign w_clr_ovr  = w_wr && (w_off == 2'd1) && WD[2];
    assign w_unused   = ^{WD[31:10], A[1:0]};

    assign sckPort  = r_sck;
    assign mosiPort = r_mosi;
    assign csnPort  = ~r_cs;
    assign spiIRQ   = r_rxv & r_ie;

    always_comb begin
        RD = 32'b0;
        if (sel) begin
            case (w_off)
                2'd0:    RD = {22'b0, r_ie, r_cs, r_div};
                2'd1:    RD = {29'b0, r_ovr, r_rxv, w_busy};
                2'd3:    RD = {24'b0, r_rxdata};
                default: RD = 32'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tx_start) w_state_nxt = S_LOW;
            S_LOW:   if (w_div_hit)  w_state_nxt = S_HIGH;
            S_HIGH:  if (w_div_hit)  w_state_nxt = (r_bitcnt == 3'd7) ? S_IDLE : S_LOW;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_div     <= DIV_RESET;
            r_cs      <= 1'b0;
            r_ie      <= 1'b0;
            r_rxv     <= 1'b0;
            r_ovr     <= 1'b0;
            r_rxdata  <= 8'd0;
            r_shreg   <= 8'd0;
            r_bitcnt  <= 3'd0;
            r_divcnt  <= 8'd0;
            r_div_act <= 8'd0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            if (w_wr && (w_off == 2'd0)) begin
                r_div <= WD[7:0];
                r_cs  <= WD[8];
                r_ie  <= WD[9];
            end
            // Completion beats a same-cycle clear; overrun uses the pre-clear RXV.
            if (w_done)         r_rxv <= 1'b1;
            else if (w_clr_rxv) r_rxv <= 1'b0;
            if (w_done && r_rxv) r_ovr <= 1'b1;
            else if (w_clr_ovr)  r_ovr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_tx_start) begin
                        r_shreg   <= WD[7:0];
                        r_mosi    <= WD[7];
                        r_bitcnt  <= 3'd0;
                        r_divcnt  <= 8'd0;
                        r_div_act <= r_div;
                    end
                end
                S_LOW: begin
                    if (w_div_hit) begin
                        r_sck    <= 1'b1;
                        r_shreg  <= {r_shreg[6:0], misoPort};
                        r_divcnt <= 8'd0;
                    end else begin
                        r_divcnt <= r_divcnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_div_hit) begin
                        r_sck    <= 1'b0;
                        r_divcnt <= 8'd0;
                        if (r_bitcnt != 3'd7) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_mosi   <= r_shreg[7];
                        end else begin
                            r_rxdata <= r_shreg;
                        end
                    end else begin
                        r_divcnt <= r_divcnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: bus-level register access plus an SPI slave
// that shifts a chosen byte out on MISO and records MOSI at each SCK rise.
module tb_spi_controller;

    localparam logic [31:0] BASE = 32'h0000_2200;

    logic        CLK;
    logic        reset;
    logic [31:0] A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        sel;
    logic        sckPort;
    logic        mosiPort;
    logic        misoPort;
    logic        csnPort;
    logic        spiIRQ;

    int n_err = 0;
    int n_chk = 0;

    // reference model of the status bits and received byte
    bit       m_rxv = 0;
    bit       m_ovr = 0;
    bit [7:0] m_rx  = 0;

    spi_controller #(.BASE_ADDR(32'h0000_2200), .DIV_RESET(8'd3)) dut (
        .CLK(CLK), .reset(reset), .A(A), .WE(WE), .WD(WD), .RD(RD), .sel(sel),
        .sckPort(sckPort), .mosiPort(mosiPort), .misoPort(misoPort),
        .csnPort(csnPort), .spiIRQ(spiIRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        A  = BASE + {28'd0, off};
        WD = d;
        WE = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        A = BASE + {28'd0, off};
        #1;
        d = RD;
    endtask

    // Frame completion as seen by software: new byte, RXV set, overrun if RXV was pending.
    function automatic void model_done(input bit [7:0] mi, input bit clr_ovr_same);
        m_ovr = (m_ovr && !clr_ovr_same) || m_rxv;
        m_rxv = 1'b1;
        m_rx  = mi;
    endfunction

    task automatic run_frame(input logic [7:0] tx, input logic [7:0] mi, input int d,
                             input int inj_k, input logic [31:0] inj_a, input logic [31:0] inj_d,
                             output logic [7:0] mosi_b, output int busy_n, output int first_rise,
                             output int pulses, output int high_n, output bit timeout);
        int  idx;
        bit  prev_sck;
        logic [31:0] s;
        misoPort = mi[7];
        idx = 0; mosi_b = 8'd0; busy_n = 0; first_rise = -1; pulses = 0; high_n = 0;
        timeout = 1'b1; prev_sck = 1'b0;
        wr(4'h8, {24'd0, tx});
        for (int k = 0; k < 16 * (d + 1) + 40; k++) begin
            rd(4'h4, s);
            if (!s[0]) begin
                timeout = 1'b0;
                break;
            end
            busy_n++;
            if (sckPort) high_n++;
            if (sckPort && !prev_sck) begin
                if (first_rise < 0) first_rise = k;
                if (pulses < 8) mosi_b[7 - pulses] = mosiPort;
                pulses++;
            end
            if (!sckPort && prev_sck) begin
                idx++;
                if (idx < 8) misoPort = mi[7 - idx];
            end
            prev_sck = sckPort;
            if (k == inj_k) begin
                A = inj_a; WD = inj_d; WE = 1'b1;
            end
            @(posedge CLK);
            #1;
            WE = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; WE = 1'b0; A = 32'd0; WD = 32'd0; misoPort = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        rd(4'h0, v);
        n_chk++; if (v !== 32'h3) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", v, 32'h3); end
        rd(4'h4, v);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 0", v); end
        rd(4'hC, v);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_rxdata: got %h expected 0", v); end
        rd(4'h8, v);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL txdata_read: got %h expected 0", v); end
        A = BASE + 32'h10; #1;
        n_chk++; if (sel !== 1'b0 || RD !== 32'h0) begin n_err++; $display("FAIL sel_outside: sel=%b rd=%h expected 0/0", sel, RD); end
        A = BASE + 32'h4; #1;
        n_chk++; if (sel !== 1'b1) begin n_err++; $display("FAIL sel_inside: got %b expected 1", sel); end
        n_chk++;
        if (csnPort !== 1'b1 || sckPort !== 1'b0 || mosiPort !== 1'b0 || spiIRQ !== 1'b0) begin
            n_err++; $display("FAIL reset_pins: csn=%b sck=%b mosi=%b irq=%b expected 1/0/0/0", csnPort, sckPort, mosiPort, spiIRQ);
        end
        m_rxv = 0; m_ovr = 0; m_rx = 0;
    endtask

    task automatic check_frame(input string nm, input logic [7:0] tx, input int d,
                               input logic [7:0] mosi_b, input int busy_n, input int first_rise,
                               input int pulses, input int high_n, input bit timeout);
        logic [31:0] v;
        n_chk++; if (timeout) begin n_err++; $display("FAIL %s_timeout: busy never dropped", nm); end
        n_chk++; if (mosi_b !== tx) begin n_err++; $display("FAIL %s_mosi: got %h expected %h", nm, mosi_b, tx); end
        n_chk++; if (busy_n != 16 * (d + 1)) begin n_err++; $display("FAIL %s_busy: got %0d expected %0d", nm, busy_n, 16 * (d + 1)); end
        n_chk++; if (first_rise != d + 1) begin n_err++; $display("FAIL %s_first_rise: got %0d expected %0d", nm, first_rise, d + 1); end
        n_chk++;
        if (pulses != 8 || high_n != 8 * (d + 1)) begin
            n_err++; $display("FAIL %s_sck: pulses=%0d high=%0d expected 8/%0d", nm, pulses, high_n, 8 * (d + 1));
        end
        rd(4'hC, v);
        n_chk++; if (v !== {24'd0, m_rx}) begin n_err++; $display("FAIL %s_rxdata: got %h expected %h", nm, v, m_rx); end
        rd(4'h4, v);
        n_chk++; if (v !== {29'd0, m_ovr, m_rxv, 1'b0}) begin n_err++; $display("FAIL %s_status: got %h expected %h", nm, v, {29'd0, m_ovr, m_rxv, 1'b0}); end
    endtask

    task automatic test_basic();
        logic [7:0] mb; int bn, fr, pu, hn; bit to;
        wr(4'h0, 32'h103);
        n_chk++; if (csnPort !== 1'b0) begin n_err++; $display("FAIL cs_assert: got %b expected 0", csnPort); end
        run_frame(8'hA5, 8'h3C, 3, -1, 32'd0, 32'd0, mb, bn, fr, pu, hn, to);
        model_done(8'h3C, 1'b0);
        check_frame("basic", 8'hA5, 3, mb, bn, fr, pu, hn, to);
    endtask

    task automatic test_irq();
        logic [31:0] v;
        wr(4'h0, 32'h303);
        n_chk++; if (spiIRQ !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", spiIRQ); end
        wr(4'h4, 32'h2);
        m_rxv = 0;
        n_chk++; if (spiIRQ !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", spiIRQ); end
        rd(4'h4, v);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL rxv_w1c: got %h expected 0", v); end
    endtask

    task automatic test_overrun_and_ignore();
        logic [7:0] mb, tx, mi; int bn, fr, pu, hn, highs; bit to; logic [31:0] v;
        tx = 8'($urandom); mi = 8'($urandom);
        // DIV rewritten mid-frame: this frame keeps DIV=3, the next one uses DIV=1
        run_frame(tx, mi, 3, 5, BASE + 32'h0, 32'h301, mb, bn, fr, pu, hn, to);
        model_done(mi, 1'b0);
        check_frame("ovr_a", tx, 3, mb, bn, fr, pu, hn, to);
        tx = 8'($urandom); mi = 8'($urandom);
        run_frame(tx, mi, 1, 10, BASE + 32'h8, 32'hFF, mb, bn, fr, pu, hn, to);
        model_done(mi, 1'b0);
        check_frame("ovr_b", tx, 1, mb, bn, fr, pu, hn, to);
        n_chk++; if (spiIRQ !== 1'b1) begin n_err++; $display("FAIL ovr_irq: got %b expected 1", spiIRQ); end
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            if (sckPort) highs++;
            cyc();
        end
        rd(4'h4, v);
        n_chk++; if (highs != 0 || v[0] !== 1'b0) begin n_err++; $display("FAIL no_extra_frame: sck_high=%0d busy=%b expected 0/0", highs, v[0]); end
        wr(4'h4, 32'h6);
        m_rxv = 0; m_ovr = 0;
        rd(4'h4, v);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL w1c_both: got %h expected 0", v); end
    endtask

    task automatic test_div0();
        logic [7:0] mb, mi; int bn, fr, pu, hn; bit to;
        wr(4'h0, 32'h100);
        mi = 8'($urandom);
        run_frame(8'h81, mi, 0, 15, BASE + 32'h4, 32'h2, mb, bn, fr, pu, hn, to);
        model_done(mi, 1'b0);
        check_frame("div0", 8'h81, 0, mb, bn, fr, pu, hn, to);
        mi = 8'($urandom);
        run_frame(8'h7E, mi, 0, 15, BASE + 32'h4, 32'h4, mb, bn, fr, pu, hn, to);
        model_done(mi, 1'b1);
        check_frame("div0_ovr", 8'h7E, 0, mb, bn, fr, pu, hn, to);
    endtask

    task automatic test_random();
        logic [7:0] mb, tx, mi; int bn, fr, pu, hn, d; bit to;
        for (int i = 0; i < 4; i++) begin
            wr(4'h4, 32'h6);
            m_rxv = 0; m_ovr = 0;
            d = $urandom_range(0, 3);
            wr(4'h0, 32'h100 | d);
            tx = 8'($urandom); mi = 8'($urandom);
            run_frame(tx, mi, d, -1, 32'd0, 32'd0, mb, bn, fr, pu, hn, to);
            model_done(mi, 1'b0);
            check_frame("rand", tx, d, mb, bn, fr, pu, hn, to);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v; int highs;
        wr(4'h4, 32'h6);
        wr(4'h0, 32'h101);
        misoPort = 1'b1;
        wr(4'h8, 32'h5A);
        for (int i = 0; i < 18; i++) cyc();
        rd(4'h4, v);
        n_chk++; if (v[0] !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", v[0]); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rd(4'h4, v);
        n_chk++; if (v !== 32'h0 || sckPort !== 1'b0) begin n_err++; $display("FAIL mid_reset: status=%h sck=%b expected 0/0", v, sckPort); end
        rd(4'h0, v);
        n_chk++; if (v !== 32'h3 || csnPort !== 1'b1) begin n_err++; $display("FAIL mid_reset_ctrl: ctrl=%h csn=%b expected 3/1", v, csnPort); end
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            if (sckPort) highs++;
            cyc();
        end
        rd(4'h4, v);
        n_chk++; if (highs != 0 || v !== 32'h0) begin n_err++; $display("FAIL mid_reset_quiet: sck_high=%0d status=%h expected 0/0", highs, v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_irq();
        test_overrun_and_ignore();
        test_div0();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
